// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and pixel types for the sprite renderer.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE   = 640;
  localparam int unsigned VGA_H_FP       = 16;
  localparam int unsigned VGA_H_SYNC     = 96;
  localparam int unsigned VGA_H_BP       = 48;
  localparam int unsigned VGA_V_ACTIVE   = 480;
  localparam int unsigned VGA_V_FP       = 10;
  localparam int unsigned VGA_V_SYNC     = 2;
  localparam int unsigned VGA_V_BP       = 33;
  localparam int unsigned VGA_SCALE_LOG2 = 2;

  // Counters are sized for totals up to 1024; sprite deltas need one extra bit.
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned DELTA_W = 11;

  typedef logic [5:0] rgb222_t;
  typedef logic [1:0] pal_idx_t;

endpackage

// File: rtl/sprite_rom.sv
// Combinational 8x8 2bpp sprite bitmap; each row word holds col0 in its top two bits.
module sprite_rom
  import vga_pkg::*;
(
  input  logic [2:0] row,
  input  logic [2:0] col,
  output pal_idx_t   idx_c
);

  logic [15:0] line;
  logic [3:0]  sel;

  always_comb begin
    case (row)
      3'd0:    line = 16'h1550;
      3'd1:    line = 16'h6AA4;
      3'd2:    line = 16'h6FE4;
      3'd3:    line = 16'h6CE4;
      3'd4:    line = 16'h6FE4;
      3'd5:    line = 16'h6AA4;
      3'd6:    line = 16'h1550;
      default: line = 16'hC002;
    endcase
    sel   = {~col, 1'b0};
    idx_c = line[sel +: 2];
  end

endmodule

// File: rtl/vga_sprite_renderer.sv
// VGA timing generator rendering a frame-shadowed, scaled 8x8 ROM sprite over a solid background.
// Optional VGA_SPRITE_BORDER_EN draws a 1-pixel frame in color4 around the active area.
module vga_sprite_renderer
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter int unsigned SCALE_LOG2 = VGA_SCALE_LOG2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  rgb222_t    color1_i,
  input  rgb222_t    color2_i,
  input  rgb222_t    color3_i,
  input  rgb222_t    color4_i,
  input  logic [7:0] sprite_x_i,
  input  logic [7:0] sprite_y_i,
  input  logic [4:0] misc_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       de_o,
  output rgb222_t    rgb_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_STOP  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_STOP  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DELTA_W-1:0] SPR_SIZE = DELTA_W'(8 << SCALE_LOG2);

  logic [CNT_W-1:0]   hcount, vcount;
  logic               capture_c;
  rgb222_t            sh_color1, sh_color2, sh_color3, sh_color4;
  logic [7:0]         sh_x, sh_y;
  logic [4:0]         sh_misc;
  logic [DELTA_W-1:0] dx_c, dy_c;
  logic               hit_c, active_c, hs_c, vs_c;
  logic [2:0]         col_c, row_c;
  logic               s1_hit, s1_de, s1_hs, s1_vs;
  logic [2:0]         s1_col, s1_row;
  pal_idx_t           rom_idx;
  rgb222_t            pal_c, pix_c;
`ifdef VGA_SPRITE_BORDER_EN
  logic               border_c, s1_border;
`endif

  // Raster counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  // Register shadows: follow inputs in reset, otherwise one capture at vblank start.
  assign capture_c = rst_i || (hcount == '0 && vcount == V_ACT);

  always_ff @(posedge clk_i) begin
    if (capture_c) begin
      sh_color1 <= color1_i;
      sh_color2 <= color2_i;
      sh_color3 <= color3_i;
      sh_color4 <= color4_i;
      sh_x      <= sprite_x_i;
      sh_y      <= sprite_y_i;
      sh_misc   <= misc_i;
    end
  end

  // Stage 1: sprite hit test and texel address; a negative delta wraps large and misses.
  always_comb begin
    dx_c     = DELTA_W'(hcount) - DELTA_W'({sh_x, 1'b0});
    dy_c     = DELTA_W'(vcount) - DELTA_W'({sh_y, 1'b0});
    hit_c    = (dx_c < SPR_SIZE) && (dy_c < SPR_SIZE) && sh_misc[0];
    col_c    = dx_c[SCALE_LOG2 +: 3];
    row_c    = dy_c[SCALE_LOG2 +: 3];
    if (sh_misc[1]) col_c = ~col_c;
    if (sh_misc[2]) row_c = ~row_c;
    active_c = (hcount < H_ACT) && (vcount < V_ACT);
    hs_c     = !((hcount >= HS_START) && (hcount < HS_STOP));
    vs_c     = !((vcount >= VS_START) && (vcount < VS_STOP));
`ifdef VGA_SPRITE_BORDER_EN
    border_c = (hcount == '0) || (hcount == H_ACT - 1'b1) ||
               (vcount == '0) || (vcount == V_ACT - 1'b1);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_hit <= 1'b0;
      s1_col <= '0;
      s1_row <= '0;
      s1_de  <= 1'b0;
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
`ifdef VGA_SPRITE_BORDER_EN
      s1_border <= 1'b0;
`endif
    end else begin
      s1_hit <= hit_c;
      s1_col <= col_c;
      s1_row <= row_c;
      s1_de  <= active_c;
      s1_hs  <= hs_c;
      s1_vs  <= vs_c;
`ifdef VGA_SPRITE_BORDER_EN
      s1_border <= border_c;
`endif
    end
  end

  sprite_rom u_rom (
    .row   (s1_row),
    .col   (s1_col),
    .idx_c (rom_idx)
  );

  // Stage 2: palette lookup and colour priority (blank > border > sprite > background).
  always_comb begin
    case (rom_idx)
      2'd1:    pal_c = sh_color2;
      2'd2:    pal_c = sh_color3;
      default: pal_c = sh_color4;
    endcase
    pix_c = sh_misc[3] ? ~sh_color1 : sh_color1;
    if (s1_hit && (rom_idx != 2'd0)) pix_c = pal_c;
`ifdef VGA_SPRITE_BORDER_EN
    if (s1_border) pix_c = sh_color4;
`endif
    if (!s1_de || sh_misc[4]) pix_c = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
      de_o    <= 1'b0;
      rgb_o   <= '0;
    end else begin
      hsync_o <= s1_hs;
      vsync_o <= s1_vs;
      de_o    <= s1_de;
      rgb_o   <= pix_c;
    end
  end

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Directed bench for vga_sprite_renderer using a reduced raster so several frames fit in a short run.
module tb_vga_sprite_renderer;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4, HT = HA + HFP + HS + HBP;
  localparam int VA = 80, VFP = 2, VS = 2, VBP = 4, VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  localparam bit [1:0] ROM_TB [64] = '{
    0,1,1,1,1,1,0,0,
    1,2,2,2,2,2,1,0,
    1,2,3,3,3,2,1,0,
    1,2,3,0,3,2,1,0,
    1,2,3,3,3,2,1,0,
    1,2,2,2,2,2,1,0,
    0,1,1,1,1,1,0,0,
    3,0,0,0,0,0,0,2};

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] color1, color2, color3, color4;
  logic [7:0] sx, sy;
  logic [4:0] misc;
  logic       hsync, vsync, de;
  logic [5:0] rgb;

  int tests = 0;
  int fails = 0;
  int t = 0;

  // Expected shadow state for the frame currently on the output.
  logic [5:0] m_c1, m_c2, m_c3, m_c4;
  int         m_x, m_y;
  logic [4:0] m_misc;

  vga_sprite_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SCALE_LOG2(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .color1_i(color1), .color2_i(color2), .color3_i(color3), .color4_i(color4),
    .sprite_x_i(sx), .sprite_y_i(sy), .misc_i(misc),
    .hsync_o(hsync), .vsync_o(vsync), .de_o(de), .rgb_o(rgb)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; output at the following negedge shows raster index t-2.
  always @(posedge clk) begin
    if (rst) t <= 0;
    else     t <= t + 1;
  end

  function automatic logic exp_hs(input int x);
    return !(x >= HA + HFP && x < HA + HFP + HS);
  endfunction

  function automatic logic exp_vs(input int y);
    return !(y >= VA + VFP && y < VA + VFP + VS);
  endfunction

  function automatic logic [5:0] exp_pix(input int x, input int y);
    int dx, dy, col, row;
    bit [1:0] idx;
    if (x >= HA || y >= VA || m_misc[4]) return 6'h00;
`ifdef VGA_SPRITE_BORDER_EN
    if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) return m_c4;
`endif
    dx = x - 2 * m_x;
    dy = y - 2 * m_y;
    if (m_misc[0] && dx >= 0 && dx < 32 && dy >= 0 && dy < 32) begin
      col = dx / 4;
      row = dy / 4;
      if (m_misc[1]) col = 7 - col;
      if (m_misc[2]) row = 7 - row;
      idx = ROM_TB[row * 8 + col];
      if (idx == 2'd1) return m_c2;
      if (idx == 2'd2) return m_c3;
      if (idx == 2'd3) return m_c4;
    end
    return m_misc[3] ? ~m_c1 : m_c1;
  endfunction

  // Hand-worked pixel values per scenario; -1 where no directed value exists.
  function automatic int hand_val(input int mode, input int x, input int y);
    if (mode == 1 && x == 5  && y == 5 ) return 'h3C;
`ifdef VGA_SPRITE_BORDER_EN
    if (mode == 1 && x == 0  && y == 0 ) return 'h15;
`endif
    if (mode == 2 && x == 19 && y == 40) return 'h03;
    if (mode == 2 && x == 20 && y == 40) return 'h03;
    if (mode == 2 && x == 24 && y == 40) return 'h30;
    if (mode == 2 && x == 52 && y == 40) return 'h03;
    if (mode == 2 && x == 32 && y == 48) return 'h15;
    if (mode == 2 && x == 32 && y == 52) return 'h03;
    if (mode == 2 && x == 20 && y == 68) return 'h15;
    if (mode == 2 && x == 51 && y == 71) return 'h0C;
    if (mode == 3 && x == 24 && y == 40) return 'h03;
    if (mode == 3 && x == 20 && y == 68) return 'h0C;
    if (mode == 3 && x == 40 && y == 68) return 'h03;
    if (mode == 3 && x == 51 && y == 68) return 'h15;
    if (mode == 4 && x == 60 && y == 40) return 'h30;
    if (mode == 4 && x == 20 && y == 68) return 'h03;
    if (mode == 4 && x == 40 && y == 68) return 'h0C;
    return -1;
  endfunction

  task automatic goto(input int tgt);
    int n = 0;
    while ((t - 2) < tgt && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if ((t - 2) != tgt) begin
      tests++;
      fails++;
      $display("FAIL goto: raster index %0d, required %0d", t - 2, tgt);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (hsync !== 1'b1) begin fails++; $display("FAIL reset_hsync: got %b, required 1", hsync); end
    tests++; if (vsync !== 1'b1) begin fails++; $display("FAIL reset_vsync: got %b, required 1", vsync); end
    tests++; if (de !== 1'b0)    begin fails++; $display("FAIL reset_de: got %b, required 0", de); end
    tests++; if (rgb !== 6'h00)  begin fails++; $display("FAIL reset_rgb: got %h, required 00", rgb); end
    rst = 1'b0;
  endtask

  // Frame 0: full timing check; misc change inside the frame must not show yet.
  task automatic test_timing();
    int hs_err = 0, vs_err = 0, de_err = 0, rgb_err = 0;
    int hs_line0 = 0, hs_low = 0, vs_low = 0, de_cnt = 0, x, y;
    misc = 5'b01000;
    for (int p = 0; p < FRAME; p++) begin
      goto(p);
      x = p % HT;
      y = p / HT;
      if (hsync !== exp_hs(x)) hs_err++;
      if (vsync !== exp_vs(y)) vs_err++;
      if (de !== (x < HA && y < VA)) de_err++;
      if (rgb !== exp_pix(x, y)) rgb_err++;
      if (hsync === 1'b0) begin hs_low++; if (y == 0) hs_line0++; end
      if (vsync === 1'b0) vs_low++;
      if (de === 1'b1) de_cnt++;
    end
    tests++; if (hs_err != 0)  begin fails++; $display("FAIL hsync_timing: %0d wrong cycles, required 0", hs_err); end
    tests++; if (vs_err != 0)  begin fails++; $display("FAIL vsync_timing: %0d wrong cycles, required 0", vs_err); end
    tests++; if (de_err != 0)  begin fails++; $display("FAIL de_timing: %0d wrong cycles, required 0", de_err); end
    tests++; if (rgb_err != 0) begin fails++; $display("FAIL solid_bg: %0d wrong pixels, required 0", rgb_err); end
    tests++; if (hs_line0 != HS) begin fails++; $display("FAIL hsync_width: got %0d, required %0d", hs_line0, HS); end
    tests++; if (hs_low != HS * VT) begin fails++; $display("FAIL hsync_total: got %0d, required %0d", hs_low, HS * VT); end
    tests++; if (vs_low != VS * HT) begin fails++; $display("FAIL vsync_total: got %0d, required %0d", vs_low, VS * HT); end
    tests++; if (de_cnt != HA * VA) begin fails++; $display("FAIL de_total: got %0d, required %0d", de_cnt, HA * VA); end
    m_misc = 5'b01000;
  endtask

  // Frame 1: inverted background; sprite settings written mid-frame for frame 2.
  task automatic test_invert();
    int err = 0, x, y, e;
    for (int p = FRAME; p < 2 * FRAME; p++) begin
      goto(p);
      x = (p - FRAME) % HT;
      y = (p - FRAME) / HT;
      if (x == 0 && y == 10) begin sx = 8'd10; sy = 8'd20; misc = 5'b00001; end
      if (rgb !== exp_pix(x, y)) err++;
      e = hand_val(1, x, y);
      if (e >= 0) begin
        tests++;
        if (rgb !== 6'(e)) begin fails++; $display("FAIL invert_pix(%0d,%0d): got %h, required %h", x, y, rgb, 6'(e)); end
      end
    end
    tests++; if (err != 0) begin fails++; $display("FAIL invert_frame: %0d wrong pixels, required 0", err); end
    m_x = 10; m_y = 20; m_misc = 5'b00001;
  endtask

  // Frame 2: sprite at (20,40); mirror X requested mid-sprite for frame 3.
  task automatic test_sprite();
    int err = 0, x, y, e;
    for (int p = 2 * FRAME; p < 3 * FRAME; p++) begin
      goto(p);
      x = (p - 2 * FRAME) % HT;
      y = (p - 2 * FRAME) / HT;
      if (x == 0 && y == 50) misc = 5'b00011;
      if (rgb !== exp_pix(x, y)) err++;
      e = hand_val(2, x, y);
      if (e >= 0) begin
        tests++;
        if (rgb !== 6'(e)) begin fails++; $display("FAIL sprite_pix(%0d,%0d): got %h, required %h", x, y, rgb, 6'(e)); end
      end
    end
    tests++; if (err != 0) begin fails++; $display("FAIL sprite_frame: %0d wrong pixels, required 0", err); end
    m_misc = 5'b00011;
  endtask

  // Frame 3: mirrored sprite; sprite_x moved at line 50 must not tear this frame.
  task automatic test_mirror();
    int err = 0, x, y, e;
    for (int p = 3 * FRAME; p < 4 * FRAME; p++) begin
      goto(p);
      x = (p - 3 * FRAME) % HT;
      y = (p - 3 * FRAME) / HT;
      if (x == 0 && y == 50) sx = 8'd20;
      if (rgb !== exp_pix(x, y)) err++;
      e = hand_val(3, x, y);
      if (e >= 0) begin
        tests++;
        if (rgb !== 6'(e)) begin fails++; $display("FAIL mirror_pix(%0d,%0d): got %h, required %h", x, y, rgb, 6'(e)); end
      end
    end
    tests++; if (err != 0) begin fails++; $display("FAIL mirror_frame: %0d wrong pixels, required 0", err); end
    m_x = 20;
  endtask

  // Frame 4: sprite at its new position, clipped at the right edge; blank requested for frame 5.
  task automatic test_move();
    int err = 0, x, y, e;
    for (int p = 4 * FRAME; p < 5 * FRAME; p++) begin
      goto(p);
      x = (p - 4 * FRAME) % HT;
      y = (p - 4 * FRAME) / HT;
      if (x == 0 && y == 50) misc = 5'b10011;
      if (rgb !== exp_pix(x, y)) err++;
      e = hand_val(4, x, y);
      if (e >= 0) begin
        tests++;
        if (rgb !== 6'(e)) begin fails++; $display("FAIL move_pix(%0d,%0d): got %h, required %h", x, y, rgb, 6'(e)); end
      end
    end
    tests++; if (err != 0) begin fails++; $display("FAIL move_frame: %0d wrong pixels, required 0", err); end
    m_misc = 5'b10011;
  endtask

  // Frame 5: blank forces black while sync and de keep running.
  task automatic test_blank();
    int nz = 0, sync_err = 0, de_cnt = 0, x, y;
    for (int p = 5 * FRAME; p < 6 * FRAME; p++) begin
      goto(p);
      x = (p - 5 * FRAME) % HT;
      y = (p - 5 * FRAME) / HT;
      if (rgb !== 6'h00) nz++;
      if (hsync !== exp_hs(x) || vsync !== exp_vs(y)) sync_err++;
      if (de === 1'b1) de_cnt++;
    end
    tests++; if (nz != 0)       begin fails++; $display("FAIL blank_rgb: %0d nonzero pixels, required 0", nz); end
    tests++; if (sync_err != 0) begin fails++; $display("FAIL blank_sync: %0d wrong cycles, required 0", sync_err); end
    tests++; if (de_cnt != HA * VA) begin fails++; $display("FAIL blank_de: got %0d, required %0d", de_cnt, HA * VA); end
  endtask

  // Reset mid-frame: outputs clear next cycle, raster restarts at (0,0) with fresh shadows.
  task automatic test_reset_mid();
    goto(6 * FRAME + 10 * HT + 10);
    tests++; if (de !== 1'b1) begin fails++; $display("FAIL mid_pre_de: got %b, required 1", de); end
    rst = 1'b1; color1 = 6'h21; misc = 5'b00000;
    @(negedge clk);
    tests++; if (hsync !== 1'b1 || vsync !== 1'b1) begin fails++; $display("FAIL mid_reset_sync: got %b%b, required 11", hsync, vsync); end
    tests++; if (de !== 1'b0 || rgb !== 6'h00) begin fails++; $display("FAIL mid_reset_out: got de=%b rgb=%h, required de=0 rgb=00", de, rgb); end
    rst = 1'b0;
    m_c1 = 6'h21; m_misc = 5'b00000;
    @(negedge clk);
    tests++; if (de !== 1'b0) begin fails++; $display("FAIL mid_flush_de: got %b, required 0", de); end
    goto(0);
    tests++; if (de !== 1'b1 || hsync !== 1'b1) begin fails++; $display("FAIL mid_restart: got de=%b hs=%b, required de=1 hs=1", de, hsync); end
    tests++; if (rgb !== exp_pix(0, 0)) begin fails++; $display("FAIL mid_restart_rgb: got %h, required %h", rgb, exp_pix(0, 0)); end
    goto(HA + HFP);
    tests++; if (hsync !== 1'b0) begin fails++; $display("FAIL mid_hsync_start: got %b, required 0", hsync); end
  endtask

  initial begin
    rst = 1'b1;
    color1 = 6'h03; color2 = 6'h30; color3 = 6'h0C; color4 = 6'h15;
    sx = 8'd0; sy = 8'd0; misc = 5'b00000;
    m_c1 = 6'h03; m_c2 = 6'h30; m_c3 = 6'h0C; m_c4 = 6'h15;
    m_x = 0; m_y = 0; m_misc = 5'b00000;
    test_reset();
    test_timing();
    test_invert();
    test_sprite();
    test_mirror();
    test_move();
    test_blank();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
